// File: rtl/dcache_pkg.sv
// Shared types and constants for the byte-granular write-through data cache.
// Combinational helpers only; no state lives here.
package dcache_pkg;

    localparam int         CACHE_INDEX_W_DEF = 7;
    localparam logic [1:0] IO_REGION         = 2'b11;

    typedef logic [7:0]  cache_one_data_t;
    typedef logic [31:0] cache_data_t;

    // Uncacheable IO window is selected by address bits 17:16.
    function automatic logic is_io(input logic [31:0] addr, input logic [1:0] mask);
        return addr[17:16] == mask;
    endfunction

endpackage

// File: rtl/dcache_lookup.sv
// Per-byte presence check with same-cycle store bypass.
// Latency: combinational. Backpressure: none (pure lookup).
// Store bypass takes precedence over the stored entry; fills are never bypassed.
module dcache_lookup
    import dcache_pkg::*;
#(
    parameter int INDEX_W = CACHE_INDEX_W_DEF
) (
    input  logic [31:0]        addr,
    input  logic               entry_valid,
    input  logic [31-INDEX_W:0] entry_tag,
    input  logic [7:0]         entry_data,
    input  logic               write_bit,
    input  logic [31:0]        write_addr,
    input  logic [7:0]         write_data,
    output logic               present,
    output logic [7:0]         data
);

    always_comb begin
        present = 1'b0;
        data    = entry_data;
        if (write_bit && (write_addr == addr)) begin
            present = 1'b1;
            data    = write_data;
        end else begin
            present = entry_valid && (entry_tag == addr[31:INDEX_W]);
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, byte-granular write-through data cache beside the MEM stage.
// Latency: lookup is combinational in the same cycle; updates land at the next posedge.
// Backpressure: none; every store/fill byte is accepted or dropped. Option: DCACHE_STAT_EN adds hit/total counters.
module dcache
    import dcache_pkg::*;
#(
    parameter int         INDEX_W    = CACHE_INDEX_W_DEF,
    parameter logic [1:0] IO_MASK_HI = IO_REGION
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] read_addr,
    output logic        cache_hit,
    output logic [31:0] cache_data,
    input  logic        write_bit,
    input  logic [2:0]  write_type,
    input  logic [31:0] write_addr,
    input  logic [7:0]  write_data,
    input  logic        fill_valid,
    input  logic [31:0] fill_addr,
    input  logic [7:0]  fill_data,
    input  logic        flush_i
`ifdef DCACHE_STAT_EN
    ,
    output logic [31:0] count_hit,
    output logic [31:0] count_total
`endif
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam int TAG_W = 32 - INDEX_W;

    logic             valid_q [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    cache_one_data_t  data_q  [DEPTH];

    logic [3:0]      present;
    cache_one_data_t bytes [4];
    logic            lookup_ok;

    // Store size is irrelevant: the MEM stage already serialises stores into bytes.
    logic write_type_unused;
    assign write_type_unused = ^write_type;

    for (genvar k = 0; k < 4; k++) begin : g_byte
        logic [31:0]        addr_k;
        logic [INDEX_W-1:0] idx_k;
        assign addr_k = read_addr + 32'(k);
        assign idx_k  = addr_k[INDEX_W-1:0];

        dcache_lookup #(.INDEX_W(INDEX_W)) u_lookup (
            .addr        (addr_k),
            .entry_valid (valid_q[idx_k]),
            .entry_tag   (tag_q[idx_k]),
            .entry_data  (data_q[idx_k]),
            .write_bit   (write_bit),
            .write_addr  (write_addr),
            .write_data  (write_data),
            .present     (present[k]),
            .data        (bytes[k])
        );
    end

    assign lookup_ok  = !rst && (&present) && !is_io(read_addr, IO_MASK_HI);
    assign cache_hit  = lookup_ok;
    assign cache_data = lookup_ok ? {bytes[3], bytes[2], bytes[1], bytes[0]} : '0;

    logic [INDEX_W-1:0] w_idx;
    logic [INDEX_W-1:0] f_idx;
    assign w_idx = write_addr[INDEX_W-1:0];
    assign f_idx = fill_addr[INDEX_W-1:0];

    // Fill is assigned before the store so a store to the same index overrides it.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            if (fill_valid && !is_io(fill_addr, IO_MASK_HI)) begin
                valid_q[f_idx] <= 1'b1;
                tag_q[f_idx]   <= fill_addr[31:INDEX_W];
                data_q[f_idx]  <= fill_data;
            end
            if (write_bit && !is_io(write_addr, IO_MASK_HI)) begin
                valid_q[w_idx] <= 1'b1;
                tag_q[w_idx]   <= write_addr[31:INDEX_W];
                data_q[w_idx]  <= write_data;
            end
        end
    end

`ifdef DCACHE_STAT_EN
    logic [31:0] prev_addr_q;
    logic        prev_clr_q;
    logic        new_lookup;

    assign new_lookup = prev_clr_q || (read_addr != prev_addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_hit   <= '0;
            count_total <= '0;
            prev_addr_q <= '0;
            prev_clr_q  <= 1'b1;
        end else begin
            prev_addr_q <= read_addr;
            prev_clr_q  <= flush_i;
            if (new_lookup) begin
                if (count_total != '1) count_total <= count_total + 32'd1;
                if (cache_hit && (count_hit != '1)) count_hit <= count_hit + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: directed vector table, then randomized traffic against an address-keyed cache model.
module tb_dcache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] read_addr;
    logic        cache_hit;
    logic [31:0] cache_data;
    logic        write_bit;
    logic [2:0]  write_type;
    logic [31:0] write_addr;
    logic [7:0]  write_data;
    logic        fill_valid;
    logic [31:0] fill_addr;
    logic [7:0]  fill_data;
    logic        flush_i;
`ifdef DCACHE_STAT_EN
    logic [31:0] count_hit;
    logic [31:0] count_total;
`endif

    dcache #(.INDEX_W(7), .IO_MASK_HI(2'b11)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_addr  (read_addr),
        .cache_hit  (cache_hit),
        .cache_data (cache_data),
        .write_bit  (write_bit),
        .write_type (write_type),
        .write_addr (write_addr),
        .write_data (write_data),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .flush_i    (flush_i)
`ifdef DCACHE_STAT_EN
        ,
        .count_hit  (count_hit),
        .count_total(count_total)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, got, exp);
    endtask

    // Model: each of the 128 slots remembers the full byte address it holds.
    typedef struct {
        bit          v;
        logic [31:0] a;
        logic [7:0]  d;
    } ent_t;
    ent_t m [128];

    logic [31:0] sm_hit, sm_total, sm_prev;
    bit          sm_clr;
    logic        last_hit;

    function automatic bit in_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    task automatic model_lookup(output logic h, output logic [31:0] d);
        logic all_p;
        all_p = 1'b1;
        d = '0;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            logic [7:0]  b;
            logic        p;
            a = read_addr + 32'(k);
            if (write_bit && write_addr == a) begin
                p = 1'b1;
                b = write_data;
            end else begin
                p = m[a[6:0]].v && (m[a[6:0]].a == a);
                b = m[a[6:0]].d;
            end
            all_p = all_p & p;
            d[8*k +: 8] = b;
        end
        h = all_p && !rst && !in_io(read_addr);
        if (!h) d = '0;
    endtask

    task automatic model_update();
        if (rst || flush_i) begin
            for (int i = 0; i < 128; i++) m[i].v = 0;
        end else begin
            if (fill_valid && !in_io(fill_addr))
                m[fill_addr[6:0]] = '{1, fill_addr, fill_data};
            if (write_bit && !in_io(write_addr))
                m[write_addr[6:0]] = '{1, write_addr, write_data};
        end
        if (rst) begin
            sm_hit = 0; sm_total = 0; sm_prev = 0; sm_clr = 1;
        end else begin
            if (sm_clr || read_addr != sm_prev) begin
                if (sm_total != 32'hFFFF_FFFF) sm_total++;
                if (last_hit && sm_hit != 32'hFFFF_FFFF) sm_hit++;
            end
            sm_prev = read_addr;
            sm_clr  = flush_i;
        end
    endtask

    // Inputs are already applied; compare outputs mid-cycle, then clock once.
    task automatic tick(input string name, input bit use_model, input logic ehit, input logic [31:0] edata);
        logic        mh;
        logic [31:0] md;
        #3;
        model_lookup(mh, md);
        last_hit = mh;
        if (use_model) begin
            ehit  = mh;
            edata = md;
        end
        check({name, "_hit"},  {31'b0, cache_hit}, {31'b0, ehit});
        check({name, "_data"}, cache_data, edata);
        @(posedge clk);
        model_update();
        #1;
`ifdef DCACHE_STAT_EN
        check({name, "_cnt_total"}, count_total, sm_total);
        check({name, "_cnt_hit"},   count_hit,   sm_hit);
`endif
    endtask

    typedef struct {
        logic [31:0] ra;
        logic        wb;
        logic [31:0] wa;
        logic [7:0]  wd;
        logic        fv;
        logic [31:0] fa;
        logic [7:0]  fd;
        logic        fl;
        logic        hit;
        logic [31:0] data;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(logic [31:0] ra, logic wb, logic [31:0] wa, logic [7:0] wd,
                                logic fv, logic [31:0] fa, logic [7:0] fd, logic fl,
                                logic hit, logic [31:0] data);
        return '{ra, wb, wa, wd, fv, fa, fd, fl, hit, data};
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 383));
        if ($urandom_range(0, 7) == 0) a = a | 32'h0003_0000;
        return a;
    endfunction

    initial begin
        // basic store then lookup
        vt.push_back(mk(32'h100, 0, 0,      8'h00, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h100, 1, 32'h100, 8'hEF, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h100, 1, 32'h101, 8'hBE, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h100, 1, 32'h102, 8'hAD, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h100, 1, 32'h103, 8'hDE, 0, 0, 8'h00, 0, 1, 32'hDEADBEEF));
        vt.push_back(mk(32'h100, 0, 0,      8'h00, 0, 0, 8'h00, 0, 1, 32'hDEADBEEF));
        vt.push_back(mk(32'h101, 0, 0,      8'h00, 0, 0, 8'h00, 0, 0, 32'h0));
        // conflicting tags on index 0; fills not bypassed
        vt.push_back(mk(32'h000, 1, 32'h000, 8'h11, 0, 0,      8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h000, 1, 32'h080, 8'h22, 0, 0,      8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h000, 0, 0,      8'h00, 0, 0,      8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h080, 0, 0,      8'h00, 1, 32'h081, 8'h33, 0, 0, 32'h0));
        vt.push_back(mk(32'h080, 0, 0,      8'h00, 1, 32'h082, 8'h44, 0, 0, 32'h0));
        vt.push_back(mk(32'h080, 0, 0,      8'h00, 1, 32'h083, 8'h55, 0, 0, 32'h0));
        vt.push_back(mk(32'h080, 0, 0,      8'h00, 0, 0,      8'h00, 0, 1, 32'h55443322));
        // store bypass on byte 0
        vt.push_back(mk(32'h200, 0, 0,      8'h00, 1, 32'h201, 8'h01, 0, 0, 32'h0));
        vt.push_back(mk(32'h200, 0, 0,      8'h00, 1, 32'h202, 8'h02, 0, 0, 32'h0));
        vt.push_back(mk(32'h200, 0, 0,      8'h00, 1, 32'h203, 8'h03, 0, 0, 32'h0));
        vt.push_back(mk(32'h200, 1, 32'h200, 8'h5A, 0, 0,      8'h00, 0, 1, 32'h0302015A));
        vt.push_back(mk(32'h200, 0, 0,      8'h00, 0, 0,      8'h00, 0, 1, 32'h0302015A));
        // flush with a concurrent store
        vt.push_back(mk(32'h300, 1, 32'h301, 8'hA1, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h300, 1, 32'h302, 8'hA2, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h300, 1, 32'h303, 8'hA3, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h300, 1, 32'h300, 8'h77, 0, 0, 8'h00, 1, 1, 32'hA3A2A177));
        vt.push_back(mk(32'h300, 0, 0,      8'h00, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h100, 0, 0,      8'h00, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h200, 0, 0,      8'h00, 0, 0, 8'h00, 0, 0, 32'h0));
        // IO stores/fills leave the array alone
        vt.push_back(mk(32'h10000, 1, 32'h10000, 8'hC0, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h10000, 1, 32'h10001, 8'hC1, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h10000, 1, 32'h10002, 8'hC2, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h10000, 1, 32'h10003, 8'hC3, 0, 0, 8'h00, 0, 1, 32'hC3C2C1C0));
        vt.push_back(mk(32'h10000, 1, 32'h30000, 8'h99, 1, 32'h30001, 8'h98, 0, 1, 32'hC3C2C1C0));
        vt.push_back(mk(32'h10000, 0, 0,        8'h00, 0, 0,        8'h00, 0, 1, 32'hC3C2C1C0));
        // IO read_addr forces a miss even with every byte present
        vt.push_back(mk(32'h40000, 0, 0,        8'h00, 1, 32'h40000, 8'hD0, 0, 0, 32'h0));
        vt.push_back(mk(32'h40000, 0, 0,        8'h00, 1, 32'h40001, 8'hD1, 0, 0, 32'h0));
        vt.push_back(mk(32'h40000, 0, 0,        8'h00, 1, 32'h40002, 8'hD2, 0, 0, 32'h0));
        vt.push_back(mk(32'h3FFFF, 1, 32'h3FFFF, 8'hEE, 0, 0,        8'h00, 0, 0, 32'h0));
        // store beats fill on a shared index
        vt.push_back(mk(32'h400, 1, 32'h401, 8'hB1, 0, 0,      8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h400, 1, 32'h402, 8'hB2, 0, 0,      8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h400, 1, 32'h403, 8'hB3, 0, 0,      8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h400, 1, 32'h400, 8'hB0, 1, 32'h480, 8'hC0, 0, 1, 32'hB3B2B1B0));
        vt.push_back(mk(32'h400, 0, 0,      8'h00, 0, 0,      8'h00, 0, 1, 32'hB3B2B1B0));
        // lookup straddling index 127 -> 0
        vt.push_back(mk(32'h17E, 1, 32'h17E, 8'hE0, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h17E, 1, 32'h17F, 8'hE1, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h17E, 1, 32'h180, 8'hE2, 0, 0, 8'h00, 0, 0, 32'h0));
        vt.push_back(mk(32'h17E, 0, 0,      8'h00, 1, 32'h181, 8'hE3, 0, 0, 32'h0));
        vt.push_back(mk(32'h17E, 0, 0,      8'h00, 0, 0,      8'h00, 0, 1, 32'hE3E2E1E0));

        for (int i = 0; i < 128; i++) m[i] = '{0, 32'h0, 8'h00};
        sm_hit = 0; sm_total = 0; sm_prev = 0; sm_clr = 1; last_hit = 0;

        rst = 1'b1; read_addr = 32'h100; write_type = 3'b010;
        write_bit = 1'b0; write_addr = '0; write_data = '0;
        fill_valid = 1'b0; fill_addr = '0; fill_data = '0; flush_i = 1'b0;
        tick("reset0", 0, 1'b0, 32'h0);
        tick("reset1", 0, 1'b0, 32'h0);
        rst = 1'b0;

        foreach (vt[i]) begin
            read_addr  = vt[i].ra;
            write_bit  = vt[i].wb; write_addr = vt[i].wa; write_data = vt[i].wd;
            fill_valid = vt[i].fv; fill_addr  = vt[i].fa; fill_data  = vt[i].fd;
            flush_i    = vt[i].fl;
            tick($sformatf("vec%0d", i), 0, vt[i].hit, vt[i].data);
        end

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) != 0) read_addr = rnd_addr();
            write_bit  = ($urandom_range(0, 1) == 1);
            write_addr = ($urandom_range(0, 1) == 1) ? read_addr + 32'($urandom_range(0, 3)) : rnd_addr();
            write_data = 8'($urandom);
            write_type = 3'($urandom_range(0, 2));
            fill_valid = ($urandom_range(0, 4) < 2);
            fill_addr  = ($urandom_range(0, 1) == 1) ? read_addr + 32'($urandom_range(0, 3)) : rnd_addr();
            fill_data  = 8'($urandom);
            flush_i    = ($urandom_range(0, 59) == 0);
            tick($sformatf("rnd%0d", c), 1, 1'b0, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
